// File: rtl/mdu_iter_if.sv
// Pipeline <-> iterative multiply/divide unit connection bundle.
// The pipeline (master) issues the EXE-stage operation, and the unit (slave) returns stall and result.
interface mdu_iter_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        exe_advance;
    logic        flush;
    logic        DIVMULTBusy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, src_a, src_b, exe_advance, flush,
        input  DIVMULTBusy, result_valid, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, exe_advance, flush,
        output DIVMULTBusy, result_valid, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit: a radix-2 shift-add multiplier and a restoring divider,
// both working on magnitudes, followed by a one-cycle sign fixup. Results are held until the EXE stage advances.
module mdu_iter #(
    parameter int CALC_CYCLES = 32
) (
    input  logic     clk,
    input  logic     rst,
    mdu_iter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [5:0] LAST_CNT = 6'(CALC_CYCLES - 1);

    logic [1:0]  state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [1:0]  op_reg;
    logic [31:0] opnd_reg;      // multiplicand for multiply, divisor for divide
    logic [63:0] acc_reg;       // multiply: {partial product, multiplier}; divide: [31:0] dividend -> quotient
    logic [31:0] rem_reg;
    logic        neg_res_reg;
    logic        neg_rem_reg;
    logic        div_zero_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // Operand sign handling at acceptance; only signed ops (op[0]=0) take magnitudes.
    logic [1:0][31:0] in_opnd;
    logic [1:0][31:0] in_mag;
    logic [1:0]       in_neg;

    assign in_opnd[0] = bus.src_a;
    assign in_opnd[1] = bus.src_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            assign in_neg[gi] = ~bus.op[0] & in_opnd[gi][31];
            assign in_mag[gi] = in_neg[gi] ? (~in_opnd[gi] + 32'd1) : in_opnd[gi];
        end
    endgenerate

    logic accept;
    logic in_is_div;
    logic in_div_zero;

    assign accept      = (state_reg == IDLE) & bus.op_valid & ~bus.flush;
    assign in_is_div   = bus.op[1];
    assign in_div_zero = in_is_div & (bus.src_b == 32'd0);

    // One multiply step: add multiplicand when the current multiplier bit is set, then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_acc_next;

    assign mul_sum      = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign mul_acc_next = {mul_sum, acc_reg[31:1]};

    // One restoring-division step on the 33-bit shifted partial remainder.
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem_next;
    logic [31:0] div_quo_next;

    assign div_shift    = {rem_reg, acc_reg[31]};
    assign div_ge       = (div_shift >= {1'b0, opnd_reg});
    assign div_rem_next = div_ge ? 32'(div_shift - {1'b0, opnd_reg}) : div_shift[31:0];
    assign div_quo_next = {acc_reg[30:0], div_ge};

    logic        is_signed;
    logic        is_div;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_next;
    logic [31:0] lo_next;

    assign is_signed = ~op_reg[0];
    assign is_div    = op_reg[1];

    assign prod_fix = (is_signed & neg_res_reg) ? (~acc_reg + 64'd1) : acc_reg;
    assign quo_fix  = (is_signed & neg_res_reg) ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    assign rem_fix  = (is_signed & neg_rem_reg) ? (~rem_reg + 32'd1) : rem_reg;

    always_comb begin
        hi_next = prod_fix[63:32];
        lo_next = prod_fix[31:0];
        if (div_zero_reg) begin
            // Divide by zero: dividend passes through untouched, quotient saturates to all ones.
            hi_next = rem_reg;
            lo_next = acc_reg[31:0];
        end else if (is_div) begin
            hi_next = rem_fix;
            lo_next = quo_fix;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.op_valid) state_next = in_div_zero ? FIXUP : CALC;
                CALC:    if (cnt_reg == LAST_CNT) state_next = FIXUP;
                FIXUP:   state_next = DONE;
                DONE:    if (bus.exe_advance) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 6'd0;
            op_reg       <= 2'd0;
            opnd_reg     <= 32'd0;
            acc_reg      <= 64'd0;
            rem_reg      <= 32'd0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                op_reg       <= bus.op;
                cnt_reg      <= 6'd0;
                neg_res_reg  <= in_neg[0] ^ in_neg[1];
                neg_rem_reg  <= in_neg[0];
                div_zero_reg <= in_div_zero;
                if (in_is_div) begin
                    opnd_reg <= in_mag[1];
                    rem_reg  <= in_div_zero ? bus.src_a : 32'd0;
                    acc_reg  <= {32'd0, in_div_zero ? 32'hFFFF_FFFF : in_mag[0]};
                end else begin
                    opnd_reg <= in_mag[0];
                    rem_reg  <= 32'd0;
                    acc_reg  <= {32'd0, in_mag[1]};
                end
            end else if (state_reg == CALC && !bus.flush) begin
                cnt_reg <= (cnt_reg == LAST_CNT) ? 6'd0 : cnt_reg + 6'd1;
                if (is_div) begin
                    rem_reg <= div_rem_next;
                    acc_reg <= {32'd0, div_quo_next};
                end else begin
                    acc_reg <= mul_acc_next;
                end
            end else if (state_reg == FIXUP && !bus.flush) begin
                hi_reg <= hi_next;
                lo_reg <= lo_next;
            end

            // A flushed operation must not leave a stale count behind for the next acceptance.
            if (bus.flush) begin
                cnt_reg <= 6'd0;
            end
        end
    end

    assign bus.DIVMULTBusy  = ~bus.flush & (((state_reg == IDLE) & bus.op_valid)
                                            | (state_reg == CALC) | (state_reg == FIXUP));
    assign bus.result_valid = (state_reg == DONE);
    assign bus.hi           = hi_reg;
    assign bus.lo           = lo_reg;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed and lightly randomised bench for mdu_iter: expected {hi,lo} go into a scoreboard queue
// at issue and are compared when result_valid appears, along with busy/latency behaviour.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mdu_iter_if bus ();

    mdu_iter #(.CALC_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [63:0] exp_q[$];
    string       tag_q[$];
    logic [63:0] last_res = 64'd0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa   = a;
        sb   = b;
        case (op)
            2'b00: model = sa64 * sb64;
            2'b01: model = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r, q};
                end
            end
            default: model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
    endfunction

    // Issue one operation with op_valid held until the result appears, hold DONE for `hold` extra cycles,
    // then advance the EXE stage and confirm the unit goes quiet.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name, input int hold);
        int          lat;
        int          busy_cnt;
        bit          done;
        logic [63:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(name);
        lat = (op[1] && b == 32'd0) ? 2 : 34;
        bus.op          = op;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.op_valid    = 1'b1;
        bus.exe_advance = 1'b0;
        settle();
        check({name, ".busy_accept"}, 64'(bus.DIVMULTBusy), 64'd1);
        busy_cnt = 1;
        done     = 1'b0;
        for (int c = 1; c <= 100 && !done; c++) begin
            next_cycle();
            settle();
            if (bus.result_valid) begin
                done = 1'b1;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, ".latency"}, 64'(c), 64'(lat));
                check({t, ".busy_cycles"}, 64'(busy_cnt), 64'(lat));
                check({t, ".busy_done"}, 64'(bus.DIVMULTBusy), 64'd0);
                check({t, ".hilo"}, {bus.hi, bus.lo}, e);
                for (int h = 0; h < hold; h++) begin
                    next_cycle();
                    settle();
                    check({t, ".hold_valid"}, 64'(bus.result_valid), 64'd1);
                    check({t, ".hold_busy"}, 64'(bus.DIVMULTBusy), 64'd0);
                    check({t, ".hold_hilo"}, {bus.hi, bus.lo}, e);
                end
                last_res = e;
            end else if (bus.DIVMULTBusy) begin
                busy_cnt++;
            end
        end
        if (!done) check({name, ".timeout"}, 64'(bus.result_valid), 64'd1);
        bus.exe_advance = 1'b1;
        next_cycle();
        bus.exe_advance = 1'b0;
        bus.op_valid    = 1'b0;
        settle();
        check({name, ".idle_valid"}, 64'(bus.result_valid), 64'd0);
        check({name, ".idle_busy"}, 64'(bus.DIVMULTBusy), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.op_valid    = 1'b0;
        bus.op          = 2'b00;
        bus.src_a       = 32'd0;
        bus.src_b       = 32'd0;
        bus.exe_advance = 1'b0;
        bus.flush       = 1'b0;

        next_cycle();
        next_cycle();
        settle();
        check("reset.busy", 64'(bus.DIVMULTBusy), 64'd0);
        check("reset.valid", 64'(bus.result_valid), 64'd0);
        check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_op(2'b01, 32'hFFFF_FFFF, 32'h2, {32'h1, 32'hFFFF_FFFE}, "multu_max", 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7", 0);
        run_op(2'b11, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, "divu_zero", 0);

        // Flush at cycle 10 of a MULT: busy drops immediately, unit idles, old hi/lo remain.
        bus.op       = 2'b00;
        bus.src_a    = 32'hFFFF_FFFD;
        bus.src_b    = 32'd5;
        bus.op_valid = 1'b1;
        settle();
        check("flush.busy_accept", 64'(bus.DIVMULTBusy), 64'd1);
        for (int c = 1; c < 10; c++) next_cycle();
        next_cycle();
        bus.flush = 1'b1;
        settle();
        check("flush.busy_in_flush", 64'(bus.DIVMULTBusy), 64'd0);
        next_cycle();
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        settle();
        check("flush.valid_after", 64'(bus.result_valid), 64'd0);
        check("flush.busy_after", 64'(bus.DIVMULTBusy), 64'd0);
        check("flush.hilo_kept", {bus.hi, bus.lo}, last_res);
        for (int c = 0; c < 40; c++) next_cycle();
        settle();
        check("flush.still_idle", 64'(bus.result_valid), 64'd0);

        // Flush and op_valid together in IDLE: nothing accepted.
        bus.op_valid = 1'b1;
        bus.flush    = 1'b1;
        settle();
        check("flush_idle.busy", 64'(bus.DIVMULTBusy), 64'd0);
        next_cycle();
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        settle();
        check("flush_idle.no_start", 64'(bus.DIVMULTBusy), 64'd0);
        next_cycle();

        run_op(2'b00, 32'd6, 32'd7, {32'd0, 32'd42}, "mult_hold", 6);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg", 0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "div_negdivisor", 0);
        run_op(2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, "div_bothneg", 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'd0}, "mult_minsq", 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_zero_signed", 0);

        // Reset in the middle of a DIVU clears everything; a fresh op follows.
        bus.op       = 2'b11;
        bus.src_a    = 32'd100;
        bus.src_b    = 32'd7;
        bus.op_valid = 1'b1;
        for (int c = 1; c < 15; c++) next_cycle();
        next_cycle();
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        settle();
        check("rst_mid.busy", 64'(bus.DIVMULTBusy), 64'd0);
        check("rst_mid.valid", 64'(bus.result_valid), 64'd0);
        check("rst_mid.hilo", {bus.hi, bus.lo}, 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        run_op(2'b01, 32'd3, 32'd4, {32'd0, 32'd12}, "multu_after_rst", 0);

        for (int i = 0; i < 4; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (rop[1] && rb == 32'd0) rb = 32'd1;
            if (rop == 2'b10 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop), 0);
        end

        check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
